serial_multiplier_n: RTL



---
 rtl/serial_multiplier_n.sv | 113 +++++++++++
 1 files changed

// File: rtl/serial_multiplier_n.sv
// Radix-2 shift-add sequential multiplier: one partial product per clock, WIDTH clocks per result.
// Optional per-operation two's-complement mode is enabled with SERIAL_MULT_SIGNED_EN.
module serial_multiplier_n #(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
`ifdef SERIAL_MULT_SIGNED_EN
  input  logic               sgn,
`endif
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] p,
  output logic [CW-1:0]      cnt
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  state_t               state, state_next;
  logic                 accept, last;
  logic [2*WIDTH-1:0]   a_ext, mcand, acc, addend, sum;
  logic [WIDTH-1:0]     b_sh;
`ifdef SERIAL_MULT_SIGNED_EN
  logic                 sgn_q;
`endif

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path leaves a latch.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last       = 1'b0;
    case (state)
      IDLE: if (start) begin
        accept     = 1'b1;
        state_next = RUN;
      end
      RUN: if (cnt == LAST_STEP) begin
        last       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == RUN);

  // The multiplicand is widened once at capture; shifting it left each step gives a*2^k.
  always_comb begin
`ifdef SERIAL_MULT_SIGNED_EN
    a_ext  = sgn ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
`else
    a_ext  = {{WIDTH{1'b0}}, a};
`endif
    addend = b_sh[0] ? mcand : '0;
`ifdef SERIAL_MULT_SIGNED_EN
    // The multiplier's sign bit carries weight -2^(W-1), hence the final subtract.
    sum    = (sgn_q && last) ? acc - addend : acc + addend;
`else
    sum    = acc + addend;
`endif
  end

  // NOTE: every datapath register is reset so an aborted run leaves no stale operands behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand <= '0;
      b_sh  <= '0;
      acc   <= '0;
      p     <= '0;
      cnt   <= '0;
      done  <= 1'b0;
`ifdef SERIAL_MULT_SIGNED_EN
      sgn_q <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (accept) begin
        mcand <= a_ext;
        b_sh  <= b;
        acc   <= '0;
        cnt   <= '0;
`ifdef SERIAL_MULT_SIGNED_EN
        sgn_q <= sgn;
`endif
      end else if (state == RUN) begin
        mcand <= mcand << 1;
        b_sh  <= b_sh >> 1;
        if (last) begin
          p    <= sum;
          done <= 1'b1;
          acc  <= '0;
          cnt  <= '0;
        end else begin
          acc  <= sum;
          cnt  <= cnt + CW'(1);
        end
      end
    end
  end

endmodule
